// File: rtl/ncl_dualrail_tx.sv
// Clocked valid/ready to dual-rail NCL producer: alternates DATA and NULL wavefronts,
// paced by the synchronized pipeline acknowledge ki.
module ncl_dualrail_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] a_r0,
  output logic [WIDTH-1:0] a_r1,
  output logic [WIDTH-1:0] b_r0,
  output logic [WIDTH-1:0] b_r1,
  output logic             cin_r0,
  output logic             cin_r1,
  input  logic             ki,
  output logic [15:0]      wf_count,
  output logic             err
);

  // state  | meaning
  // S_NULL | NULL on the rails, waiting for ki_s = 1 (request-for-data)
  // S_IDLE | NULL on the rails, ready for an operand word
  // S_DATA | captured word on the rails, waiting for ki_s = 0 (request-for-null)
  typedef enum logic [1:0] {S_NULL, S_IDLE, S_DATA} state_t;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] ki_sync;
  logic                   ki_s;
  logic [HW-1:0]          hold_cnt;
  logic [TW-1:0]          wait_cnt;
  logic                   hold_done;
  logic                   ki_ok;
  logic                   leave;
  logic                   waiting;

  // Synchronizer resets low so a fresh ki high is required before any data leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ki_sync <= '0;
    else     ki_sync <= {ki_sync[SYNC_STAGES-2:0], ki};
  end

  assign ki_s      = ki_sync[SYNC_STAGES-1];
  assign hold_done = (hold_cnt == HOLD_MAX);
  assign in_ready  = (state == S_IDLE);

  always_comb begin
    ki_ok = 1'b0;
    case (state)
      S_NULL:  ki_ok = ki_s;
      S_DATA:  ki_ok = ~ki_s;
      default: ki_ok = 1'b0;
    endcase
  end

  assign leave   = (state == S_IDLE) ? in_valid : (hold_done & ki_ok);
  assign waiting = (state != S_IDLE) & hold_done & ~ki_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_NULL;
      a_r0     <= '0;
      a_r1     <= '0;
      b_r0     <= '0;
      b_r1     <= '0;
      cin_r0   <= 1'b0;
      cin_r1   <= 1'b0;
      hold_cnt <= '0;
      wait_cnt <= '0;
      wf_count <= '0;
      err      <= 1'b0;
    end else if (leave) begin
      hold_cnt <= '0;
      wait_cnt <= '0;
      case (state)
        S_NULL: state <= S_IDLE;
        S_IDLE: begin
          state  <= S_DATA;
          a_r1   <= in_a;
          a_r0   <= ~in_a;
          b_r1   <= in_b;
          b_r0   <= ~in_b;
          cin_r1 <= in_cin;
          cin_r0 <= ~in_cin;
        end
        default: begin
          state    <= S_NULL;
          a_r0     <= '0;
          a_r1     <= '0;
          b_r0     <= '0;
          b_r1     <= '0;
          cin_r0   <= 1'b0;
          cin_r1   <= 1'b0;
          wf_count <= wf_count + 16'd1;
        end
      endcase
    end else begin
      if (!hold_done) hold_cnt <= hold_cnt + HW'(1);
      // Timeout only flags; sequencing keeps waiting on ki.
      if (waiting && wait_cnt != TO_MAX) wait_cnt <= wait_cnt + TW'(1);
      if (waiting && wait_cnt == TO_LAST) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_dualrail_tx.sv
// Directed bench for ncl_dualrail_tx: handshake timing, encoding, timeout, reset and wrap.
module tb_ncl_dualrail_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic       in_cin;
  logic [3:0] a_r0, a_r1, b_r0, b_r1;
  logic       cin_r0, cin_r1;
  logic       ki;
  logic [15:0] wf_count;
  logic       err;

  int total = 0;
  int bad   = 0;
  int ovl   = 0;
  int d2d   = 0;
  logic       auto_ki = 1'b0;
  logic [8:0] seen[$];
  logic [8:0] prev_r1 = '0;
  logic       prev_data = 1'b0;

  logic [3:0] wa[5] = '{4'b0001, 4'b1111, 4'b0110, 4'b1001, 4'b0000};
  logic [3:0] wb[5] = '{4'b1110, 4'b0000, 4'b0101, 4'b1011, 4'b1000};
  logic       wc[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  ncl_dualrail_tx #(.WIDTH(4), .SYNC_STAGES(2), .HOLD_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .a_r0(a_r0), .a_r1(a_r1), .b_r0(b_r0), .b_r1(b_r1),
    .cin_r0(cin_r0), .cin_r1(cin_r1), .ki(ki), .wf_count(wf_count), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 300) begin step(); n++; end
    chk(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_wf(input string tag, input logic [15:0] target);
    int n = 0;
    while (wf_count !== target && n < 300) begin step(); n++; end
    chk(tag, 32'(wf_count), 32'(target));
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    wait_ready("send_ready");
    step();
    in_valid = 1'b0;
  endtask

  // Rail monitor: both-rails-high, partial words, DATA->DATA without NULL, word log.
  always @(negedge clk) begin
    logic [8:0] r1, r0;
    logic is_null, is_data;
    r1 = {a_r1, b_r1, cin_r1};
    r0 = {a_r0, b_r0, cin_r0};
    is_null = ((r1 | r0) == 9'd0);
    is_data = ((r1 ^ r0) == 9'h1FF) && ((r1 & r0) == 9'd0);
    if ((r1 & r0) != 9'd0) ovl++;
    if (!is_null && !is_data) ovl++;
    if (prev_data && is_data && r1 != prev_r1) d2d++;
    if (is_data && !prev_data) seen.push_back(r1);
    prev_data = is_data;
    prev_r1   = r1;
  end

  // Random ki responder: 1-10 cycle delays in each phase.
  always begin
    @(negedge clk);
    if (auto_ki) begin
      if (ki && a_r0 != a_r1) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1 ki = 1'b0;
      end else if (!ki && a_r0 == 4'd0 && a_r1 == 4'd0) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1 ki = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1; ki = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    #12;
    chk("rst_rails", 32'({a_r0, a_r1, b_r0, b_r1, cin_r0, cin_r1}), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wf", 32'(wf_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Two sync edges then one hold edge before S_IDLE.
    step(); chk("ready_e1", 32'(in_ready), 32'd0);
    step(); chk("ready_e2", 32'(in_ready), 32'd0);
    step(); chk("ready_e3", 32'(in_ready), 32'd1);
    chk("init_rails", 32'({a_r0, a_r1, b_r0, b_r1, cin_r0, cin_r1}), 32'd0);

    in_a = 4'b1010; in_b = 4'b0011; in_cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("enc_a_r1", 32'(a_r1), 32'h0A);
    chk("enc_a_r0", 32'(a_r0), 32'h05);
    chk("enc_b_r1", 32'(b_r1), 32'h03);
    chk("enc_b_r0", 32'(b_r0), 32'h0C);
    chk("enc_cin", 32'({cin_r1, cin_r0}), 32'h2);
    chk("busy_ready", 32'(in_ready), 32'd0);

    step(); step();
    ki = 1'b0;
    step(); step();
    chk("data_held", 32'(a_r1), 32'h0A);
    chk("wf_before", 32'(wf_count), 32'd0);
    step();
    chk("null_after_ack", 32'({a_r0, a_r1, b_r0, b_r1, cin_r0, cin_r1}), 32'd0);
    chk("wf_after", 32'(wf_count), 32'd1);
    step(); step();
    ki = 1'b1;
    step(); step();
    chk("ready_wait_sync", 32'(in_ready), 32'd0);
    step();
    chk("ready_back", 32'(in_ready), 32'd1);
    chk("err_clean", 32'(err), 32'd0);

    seen.delete();
    auto_ki = 1'b1;
    for (int i = 0; i < 5; i++) send(wa[i], wb[i], wc[i]);
    wait_wf("stream_wf", 16'd6);
    wait_ready("stream_idle");
    auto_ki = 1'b0;
    chk("stream_words", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      chk("stream_order", 32'(seen[i]), 32'({wa[i], wb[i], wc[i]}));
    chk("stream_err", 32'(err), 32'd0);

    send(4'b0101, 4'b1111, 1'b0);
    repeat (17) step();
    chk("err_pre_to", 32'(err), 32'd0);
    step();
    chk("err_at_to", 32'(err), 32'd1);
    chk("to_data_held", 32'({a_r1, b_r1, cin_r1}), 32'({4'b0101, 4'b1111, 1'b0}));
    ki = 1'b0;
    wait_wf("to_complete", 16'd7);
    chk("err_sticky", 32'(err), 32'd1);
    chk("to_null", 32'({a_r0, a_r1, b_r0, b_r1, cin_r0, cin_r1}), 32'd0);
    ki = 1'b1;
    wait_ready("to_idle");

    seen.delete();
    send(4'b1100, 4'b0110, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_rails", 32'({a_r0, a_r1, b_r0, b_r1, cin_r0, cin_r1}), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_wf", 32'(wf_count), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    step(); step();
    chk("post_rst_ready_e2", 32'(in_ready), 32'd0);
    step();
    chk("post_rst_ready_e3", 32'(in_ready), 32'd1);
    chk("word_dropped", 32'(seen.size()), 32'd0);

    force dut.wf_count = 16'hFFFF;
    #1;
    release dut.wf_count;
    send(4'b0011, 4'b0101, 1'b1);
    chk("wrap_enc", 32'({a_r1, b_r1, cin_r1}), 32'({4'b0011, 4'b0101, 1'b1}));
    ki = 1'b0;
    wait_wf("wrap_wf", 16'h0000);
    ki = 1'b1;
    wait_ready("wrap_idle");

    chk("rail_overlap", 32'(ovl), 32'd0);
    chk("data_to_data", 32'(d2d), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
